// File: rtl/data_sram_responder.sv
// data_sram_responder: single-port word SRAM behind a pipelined req/addr_ok,
// data_ok/rdata handshake. Stores commit on the acceptance edge. Loads sample
// the array on the acceptance edge. Every accepted request is answered exactly
// RESP_DELAY cycles later, in acceptance order, through a small response FIFO.
module data_sram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int OUTSTANDING = 4,
  parameter int RESP_DELAY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  localparam logic [2:0]       DELAY    = 3'(RESP_DELAY);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

  // Word array and response FIFO payload.
  logic [31:0] mem_q      [DEPTH];
  logic        ent_wr_q   [OUTSTANDING];
  logic [31:0] ent_data_q [OUTSTANDING];
  logic [2:0]  ent_age_q  [OUTSTANDING];

  // FIFO bookkeeping.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  head_valid;
  logic                  pop;
  logic                  accept;

  // The transfer size and the byte offset are informational only, and the
  // upper address bits alias onto the same words.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode: the head retires when its age reaches the delay. A slot
  // freed by that pop can be refilled in the same cycle.
  always_comb begin
    word_idx   = addr[DEPTH_LOG2+1:2];
    head_valid = (count_q != '0);
    pop        = head_valid & (ent_age_q[rd_ptr_q] == DELAY) & ~reset;
    accept     = req & ~reset & ((count_q < FULL_CNT) | pop);
    addr_ok    = accept;
    data_ok    = pop;
    rdata      = (pop & ~ent_wr_q[rd_ptr_q]) ? ent_data_q[rd_ptr_q] : 32'h0;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers. Reset drops every in-flight entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload: ages climb to the delay and hold there. A new entry starts
  // at age 1 and captures the pre-edge word for loads.
  always_ff @(posedge clk) begin
    // NOTE: payload and array storage have no reset; validity comes from count_q alone, and the array must survive reset.
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (ent_age_q[i] < DELAY) ent_age_q[i] <= ent_age_q[i] + 3'd1;
    end
    if (accept) begin
      ent_wr_q[wr_ptr_q]   <= wr;
      ent_data_q[wr_ptr_q] <= wr ? 32'h0 : mem_q[word_idx];
      ent_age_q[wr_ptr_q]  <= 3'd1;
    end
  end

  // Byte-lane store into the word array on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept & wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder.
// The main instance uses the default parameters and is checked every cycle
// against a due-cycle response model.
// A second instance with RESP_DELAY=7 covers queue-full and reset-flush
// behaviour with directed expectations.
module tb_data_sram_responder;

  localparam int D   = 2;
  localparam int OUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req7, wr7;
  logic [1:0]  size7;
  logic [3:0]  wstrb7;
  logic [31:0] addr7, wdata7;
  logic        addr_ok7, data_ok7;
  logic [31:0] rdata7;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    bit          is_wr;
    logic [31:0] data;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mdl_mem [0:1023];

  data_sram_responder u_dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  data_sram_responder #(.DEPTH_LOG2(10), .OUTSTANDING(4), .RESP_DELAY(7)) u_dut7 (
    .clk(clk), .reset(reset), .req(req7), .wr(wr7), .size(size7), .wstrb(wstrb7),
    .addr(addr7), .wdata(wdata7), .addr_ok(addr_ok7), .data_ok(data_ok7), .rdata(rdata7)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle on the main instance. Inputs are driven after the edge,
  // outputs are checked before the next edge, and the model is updated at the edge.
  task automatic step(input logic rst, input logic rq, input logic w,
                      input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    logic        pop_e, aok_e;
    logic [31:0] rd_e;
    logic [9:0]  idx;
    resp_t       e;
    reset = rst; req = rq; wr = w; wstrb = s; addr = a; wdata = d;
    size  = 2'($urandom_range(0, 2));
    #1;
    pop_e = !rst && (q.size() > 0) && (q[0].due == cyc);
    aok_e = rq && !rst && ((q.size() < OUT) || pop_e);
    rd_e  = (pop_e && !q[0].is_wr) ? q[0].data : 32'h0;
    check("addr_ok", {31'd0, addr_ok}, {31'd0, aok_e});
    check("data_ok", {31'd0, data_ok}, {31'd0, pop_e});
    check("rdata",   rdata, rd_e);
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (pop_e) void'(q.pop_front());
      if (aok_e) begin
        idx     = a[11:2];
        e.due   = cyc + D;
        e.is_wr = w;
        e.data  = w ? 32'h0 : mdl_mem[idx];
        q.push_back(e);
        if (w) begin
          for (int b = 0; b < 4; b++) begin
            if (s[b]) mdl_mem[idx][8*b +: 8] = d[8*b +: 8];
          end
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] r, a2;
    logic        e_aok, e_dok;
    logic [31:0] e_rd;

    req7 = 1'b0; wr7 = 1'b0; size7 = 2'd2; wstrb7 = 4'h0; addr7 = 32'h0; wdata7 = 32'h0;

    // Reset state: everything quiet, even with req high.
    step(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0);
    idle(3);

    // Store then load of the same word: the store answers with zero data,
    // the load returns the stored word one cycle later.
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    idle(3);

    // Partial-lane store merges into the existing word.
    step(1'b0, 1'b1, 1'b1, 4'hF,    32'h20, 32'h11223344);
    step(1'b0, 1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AA00);
    step(1'b0, 1'b1, 1'b0, 4'h0,    32'h20, 32'h0);
    idle(3);

    // Upper address bits alias onto the same word.
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_1000, 32'hA5A5_5A5A);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
    idle(3);

    // Prefill words 0..7 so that every later load has defined data.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom());
    idle(3);

    // Six back-to-back loads: addr_ok stays high and responses arrive
    // back to back, in issue order.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0);
    idle(4);

    // Random traffic over eight words, with random aliasing bits.
    for (int i = 0; i < 300; i++) begin
      r  = $urandom();
      a2 = $urandom();
      step(1'b0, r[0] | r[1], r[2], r[7:4], {a2[31:12], 7'd0, r[10:8], a2[1:0]}, $urandom());
    end
    idle(5);

    // RESP_DELAY=7 instance: five back-to-back stores. The 5th request waits
    // for the first pop, 7 cycles after the first acceptance.
    req = 1'b0;
    for (int t = 0; t < 16; t++) begin
      req7 = (t <= 7); wr7 = 1'b1; wstrb7 = 4'hF;
      addr7 = 32'h100 + 32'(t * 4); wdata7 = 32'(t);
      e_aok = (t <= 3) || (t == 7);
      e_dok = ((t >= 7) && (t <= 10)) || (t == 14);
      #1;
      check("d7_full_addr_ok", {31'd0, addr_ok7}, {31'd0, e_aok});
      check("d7_full_data_ok", {31'd0, data_ok7}, {31'd0, e_dok});
      check("d7_full_rdata",   rdata7, 32'h0);
      @(posedge clk);
      cyc++;
      #1;
    end

    // RESP_DELAY=7 instance: three entries in flight, a one-cycle reset drops
    // them, and the stored data survives the reset.
    for (int u = 0; u < 30; u++) begin
      reset = (u == 3);
      req7 = 1'b0; wr7 = 1'b0; wstrb7 = 4'h0; addr7 = 32'h0; wdata7 = 32'h0;
      e_aok = 1'b0; e_dok = 1'b0; e_rd = 32'h0;
      case (u)
        0:  begin req7 = 1'b1; wr7 = 1'b1; wstrb7 = 4'hF; addr7 = 32'h24; wdata7 = 32'h13579BDF; e_aok = 1'b1; end
        1:  begin req7 = 1'b1; addr7 = 32'h24; e_aok = 1'b1; end
        2:  begin req7 = 1'b1; wr7 = 1'b1; wstrb7 = 4'hF; addr7 = 32'h28; wdata7 = 32'h2468ACE0; e_aok = 1'b1; end
        3:  begin req7 = 1'b1; addr7 = 32'h24; end
        13: begin req7 = 1'b1; addr7 = 32'h24; e_aok = 1'b1; end
        20: begin e_dok = 1'b1; e_rd = 32'h13579BDF; end
        21: begin req7 = 1'b1; addr7 = 32'h28; e_aok = 1'b1; end
        28: begin e_dok = 1'b1; e_rd = 32'h2468ACE0; end
        default: ;
      endcase
      #1;
      check("d7_rst_addr_ok", {31'd0, addr_ok7}, {31'd0, e_aok});
      check("d7_rst_data_ok", {31'd0, data_ok7}, {31'd0, e_dok});
      check("d7_rst_rdata",   rdata7, e_rd);
      @(posedge clk);
      if (reset) q.delete();
      cyc++;
      #1;
    end
    reset = 1'b0;

    // Main instance after the shared reset: a fresh load answers on time
    // with the data that was stored before the reset.
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
